// File: rtl/wb_arbiter_2to1.sv
// Two-master, one-slave pipelined Wishbone round-robin arbiter.
// Grant is held for a whole CYC; acks/errs/read data are routed only to the owner.
module wb_arbiter_2to1 #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int CNT_WIDTH       = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   // master 0
   input  logic        m0_wb_cyc_i,
   input  logic        m0_wb_stb_i,
   input  logic        m0_wb_we_i,
   input  logic [31:0] m0_wb_adr_i,
   input  logic [31:0] m0_wb_dat_i,
   input  logic [3:0]  m0_wb_sel_i,
   output logic        m0_wb_stall_o,
   output logic        m0_wb_ack_o,
   output logic        m0_wb_err_o,
   output logic [31:0] m0_wb_dat_o,
   // master 1
   input  logic        m1_wb_cyc_i,
   input  logic        m1_wb_stb_i,
   input  logic        m1_wb_we_i,
   input  logic [31:0] m1_wb_adr_i,
   input  logic [31:0] m1_wb_dat_i,
   input  logic [3:0]  m1_wb_sel_i,
   output logic        m1_wb_stall_o,
   output logic        m1_wb_ack_o,
   output logic        m1_wb_err_o,
   output logic [31:0] m1_wb_dat_o,
   // slave
   output logic        s_wb_cyc_o,
   output logic        s_wb_stb_o,
   output logic        s_wb_we_o,
   output logic [31:0] s_wb_adr_o,
   output logic [31:0] s_wb_dat_o,
   output logic [3:0]  s_wb_sel_o,
   input  logic        s_wb_stall_i,
   input  logic        s_wb_ack_i,
   input  logic        s_wb_err_i,
   input  logic [31:0] s_wb_dat_i
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t                state_reg, state_next;
   logic                  last_grant_reg, last_grant_next;
   logic [CNT_WIDTH-1:0]  outstanding_reg, outstanding_next;

   logic [1:0]  m_cyc, m_stb, m_we;
   logic [31:0] m_adr  [2];
   logic [31:0] m_wdat [2];
   logic [3:0]  m_sel  [2];

   assign m_cyc     = {m1_wb_cyc_i, m0_wb_cyc_i};
   assign m_stb     = {m1_wb_stb_i, m0_wb_stb_i};
   assign m_we      = {m1_wb_we_i,  m0_wb_we_i};
   assign m_adr[0]  = m0_wb_adr_i;
   assign m_adr[1]  = m1_wb_adr_i;
   assign m_wdat[0] = m0_wb_dat_i;
   assign m_wdat[1] = m1_wb_dat_i;
   assign m_sel[0]  = m0_wb_sel_i;
   assign m_sel[1]  = m1_wb_sel_i;

   logic [1:0] owner;
   logic       granted;
   logic       own_idx;
   logic       own_cyc;
   logic       own_stb;
   logic       cap;
   logic       accept;
   logic       ack_fwd;
   logic       err_fwd;
   logic       retire;

   assign owner[0] = (state_reg == GRANT0);
   assign owner[1] = (state_reg == GRANT1);
   assign granted  = |owner;
   assign own_idx  = owner[1];
   assign own_cyc  = |(owner & m_cyc);
   assign own_stb  = |(owner & m_cyc & m_stb);
   assign cap      = (outstanding_reg == MAX_CNT);

   // Responses with nothing outstanding belong to an aborted cycle and are dropped.
   assign ack_fwd  = own_cyc & s_wb_ack_i & (outstanding_reg != '0);
   assign err_fwd  = own_cyc & s_wb_err_i & (outstanding_reg != '0);
   assign retire   = ack_fwd | err_fwd;
   assign accept   = s_wb_stb_o & ~s_wb_stall_i;

   assign s_wb_cyc_o = own_cyc;
   assign s_wb_stb_o = own_stb & ~cap;
   assign s_wb_we_o  = granted & m_we[own_idx];
   assign s_wb_adr_o = granted ? m_adr[own_idx]  : '0;
   assign s_wb_dat_o = granted ? m_wdat[own_idx] : '0;
   assign s_wb_sel_o = granted ? m_sel[own_idx]  : '0;

   logic [1:0]  m_stall, m_ack, m_err;
   logic [31:0] m_rdat [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master_rsp
         assign m_stall[gi] = owner[gi] ? (s_wb_stall_i | cap) : 1'b1;
         assign m_ack[gi]   = owner[gi] & ack_fwd;
         assign m_err[gi]   = owner[gi] & err_fwd;
         assign m_rdat[gi]  = owner[gi] ? s_wb_dat_i : '0;
      end
   endgenerate

   assign m0_wb_stall_o = m_stall[0];
   assign m0_wb_ack_o   = m_ack[0];
   assign m0_wb_err_o   = m_err[0];
   assign m0_wb_dat_o   = m_rdat[0];
   assign m1_wb_stall_o = m_stall[1];
   assign m1_wb_ack_o   = m_ack[1];
   assign m1_wb_err_o   = m_err[1];
   assign m1_wb_dat_o   = m_rdat[1];

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg       <= IDLE;
         last_grant_reg  <= 1'b1;
         outstanding_reg <= '0;
      end else begin
         state_reg       <= state_next;
         last_grant_reg  <= last_grant_next;
         outstanding_reg <= outstanding_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      last_grant_next  = last_grant_reg;
      outstanding_next = outstanding_reg;
      case (state_reg)
         IDLE: begin
            outstanding_next = '0;
            if (m_cyc[0] && m_cyc[1]) begin
               if (last_grant_reg) begin
                  state_next      = GRANT0;
                  last_grant_next = 1'b0;
               end else begin
                  state_next      = GRANT1;
                  last_grant_next = 1'b1;
               end
            end else if (m_cyc[0]) begin
               state_next      = GRANT0;
               last_grant_next = 1'b0;
            end else if (m_cyc[1]) begin
               state_next      = GRANT1;
               last_grant_next = 1'b1;
            end
         end
         GRANT0, GRANT1: begin
            if (!own_cyc) begin
               state_next       = IDLE;
               outstanding_next = '0;
            end else begin
               // Simultaneous accept and retire leave the count unchanged.
               case ({accept, retire})
                  2'b10:   if (!cap) outstanding_next = outstanding_reg + ONE_CNT;
                  2'b01:   outstanding_next = outstanding_reg - ONE_CNT;
                  default: outstanding_next = outstanding_reg;
               endcase
            end
         end
         default: begin
            state_next       = IDLE;
            outstanding_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1: reset, single read, round robin, cap, abort, byte write.
module tb_wb_arbiter_2to1;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i;
   logic [31:0] m0_wb_adr_i, m0_wb_dat_i;
   logic [3:0]  m0_wb_sel_i;
   logic        m0_wb_stall_o, m0_wb_ack_o, m0_wb_err_o;
   logic [31:0] m0_wb_dat_o;
   logic        m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i;
   logic [31:0] m1_wb_adr_i, m1_wb_dat_i;
   logic [3:0]  m1_wb_sel_i;
   logic        m1_wb_stall_o, m1_wb_ack_o, m1_wb_err_o;
   logic [31:0] m1_wb_dat_o;
   logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
   logic [31:0] s_wb_adr_o, s_wb_dat_o;
   logic [3:0]  s_wb_sel_o;
   logic        s_wb_stall_i, s_wb_ack_i, s_wb_err_i;
   logic [31:0] s_wb_dat_i;

   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:63];

   always #5 wb_clk_i = ~wb_clk_i;

   wb_arbiter_2to1 #(.MAX_OUTSTANDING(2), .CNT_WIDTH(2)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
      .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_sel_i(m0_wb_sel_i),
      .m0_wb_stall_o(m0_wb_stall_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
      .m0_wb_dat_o(m0_wb_dat_o),
      .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
      .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_sel_i(m1_wb_sel_i),
      .m1_wb_stall_o(m1_wb_stall_o), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
      .m1_wb_dat_o(m1_wb_dat_o),
      .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
      .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
      .s_wb_stall_i(s_wb_stall_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i),
      .s_wb_dat_i(s_wb_dat_i)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      m0_wb_cyc_i = 0; m0_wb_stb_i = 0; m0_wb_we_i = 0;
      m0_wb_adr_i = '0; m0_wb_dat_i = '0; m0_wb_sel_i = '0;
      m1_wb_cyc_i = 0; m1_wb_stb_i = 0; m1_wb_we_i = 0;
      m1_wb_adr_i = '0; m1_wb_dat_i = '0; m1_wb_sel_i = '0;
      s_wb_stall_i = 0; s_wb_ack_i = 0; s_wb_err_i = 0; s_wb_dat_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      wb_rst_i = 1;
      tick();
      tick();
      wb_rst_i = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      m0_wb_cyc_i = 1; m0_wb_adr_i = 32'h55; m1_wb_cyc_i = 1; m1_wb_adr_i = 32'h66;
      wb_rst_i = 1;
      tick();
      tick();
      $display("txn reset asserted");
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_s_cyc got %b exp 0", s_wb_cyc_o); end
      checks++; if (s_wb_stb_o !== 1'b0 || s_wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_s_stb_we got %b%b exp 00", s_wb_stb_o, s_wb_we_o); end
      checks++; if (s_wb_adr_o !== 32'h0 || s_wb_dat_o !== 32'h0 || s_wb_sel_o !== 4'h0) begin errors++; $display("FAIL rst_s_bus got adr %h dat %h sel %h exp 0", s_wb_adr_o, s_wb_dat_o, s_wb_sel_o); end
      checks++; if (m0_wb_stall_o !== 1'b1 || m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL rst_stall got %b%b exp 11", m0_wb_stall_o, m1_wb_stall_o); end
      checks++; if ({m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o} !== 4'b0000) begin errors++; $display("FAIL rst_ack_err got %b%b%b%b exp 0000", m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o); end
      wb_rst_i = 0;
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_adr_i = 32'h200;
      tick();  // GRANT1, request accepted this cycle
      checks++; if (s_wb_cyc_o !== 1'b1 || s_wb_adr_o !== 32'h200) begin errors++; $display("FAIL mid_grant_s_cyc got %b adr %h exp 1 200", s_wb_cyc_o, s_wb_adr_o); end
      tick();
      m1_wb_stb_i = 0;
      #1;
      checks++; if (dut.outstanding_reg !== 2'd1) begin errors++; $display("FAIL mid_grant_out got %0d exp 1", dut.outstanding_reg); end
      m0_wb_cyc_i = 1; m0_wb_adr_i = 32'h300;
      wb_rst_i = 1;
      #1;
      $display("txn reset mid-grant");
      checks++; if (s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL mid_rst_s_cyc got %b exp 0", s_wb_cyc_o); end
      checks++; if (m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL mid_rst_m1_stall got %b exp 1", m1_wb_stall_o); end
      checks++; if (dut.outstanding_reg !== 2'd0) begin errors++; $display("FAIL mid_rst_out got %0d exp 0", dut.outstanding_reg); end
      #2;
      wb_rst_i = 0;
      tick();  // both requesting: master 0 must win
      checks++; if (m0_wb_stall_o !== 1'b0 || m1_wb_stall_o !== 1'b1 || s_wb_adr_o !== 32'h300) begin errors++; $display("FAIL post_rst_grant got stall %b%b adr %h exp 01 300", m0_wb_stall_o, m1_wb_stall_o, s_wb_adr_o); end
      clear_inputs();
      tick();
   endtask

   task automatic test_single_read();
      do_reset();
      m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_we_i = 0; m0_wb_adr_i = 32'h10; m0_wb_sel_i = 4'hF;
      #1;
      checks++; if (m0_wb_stall_o !== 1'b1 || s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL idle_arb got stall %b cyc %b exp 1 0", m0_wb_stall_o, s_wb_cyc_o); end
      tick();
      $display("txn m0 read adr=%h", m0_wb_adr_i);
      checks++; if (s_wb_cyc_o !== 1'b1 || s_wb_stb_o !== 1'b1 || s_wb_adr_o !== 32'h10 || m0_wb_stall_o !== 1'b0) begin errors++; $display("FAIL read_req got cyc %b stb %b adr %h stall %b exp 1 1 10 0", s_wb_cyc_o, s_wb_stb_o, s_wb_adr_o, m0_wb_stall_o); end
      tick();
      m0_wb_stb_i = 0; s_wb_ack_i = 1; s_wb_dat_i = 32'hDEADBEEF;
      #1;
      checks++; if (m0_wb_ack_o !== 1'b1 || m0_wb_dat_o !== 32'hDEADBEEF) begin errors++; $display("FAIL read_ack got ack %b dat %h exp 1 deadbeef", m0_wb_ack_o, m0_wb_dat_o); end
      checks++; if (m1_wb_ack_o !== 1'b0 || m1_wb_dat_o !== 32'h0) begin errors++; $display("FAIL read_m1_quiet got ack %b dat %h exp 0 0", m1_wb_ack_o, m1_wb_dat_o); end
      tick();
      s_wb_ack_i = 0; s_wb_dat_i = '0; m0_wb_cyc_i = 0;
      #1;
      checks++; if (s_wb_cyc_o !== 1'b0 || m0_wb_stall_o !== 1'b0) begin errors++; $display("FAIL release_cycle got cyc %b stall %b exp 0 0", s_wb_cyc_o, m0_wb_stall_o); end
      tick();
      checks++; if (m0_wb_stall_o !== 1'b1) begin errors++; $display("FAIL back_to_idle got stall %b exp 1", m0_wb_stall_o); end
      // error response routed to the owner only
      m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_adr_i = 32'h14;
      tick();
      tick();
      m0_wb_stb_i = 0; s_wb_err_i = 1;
      #1;
      $display("txn m0 read adr=%h err", m0_wb_adr_i);
      checks++; if (m0_wb_err_o !== 1'b1 || m1_wb_err_o !== 1'b0 || m0_wb_ack_o !== 1'b0) begin errors++; $display("FAIL err_route got m0err %b m1err %b m0ack %b exp 1 0 0", m0_wb_err_o, m1_wb_err_o, m0_wb_ack_o); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_owner [4];
      exp_owner[0] = 2'b01; exp_owner[1] = 2'b10; exp_owner[2] = 2'b01; exp_owner[3] = 2'b10;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         m0_wb_cyc_i = 1; m1_wb_cyc_i = 1;
         tick();
         $display("txn round %0d grant stall m1m0=%b%b", r, m1_wb_stall_o, m0_wb_stall_o);
         checks++; if ({m1_wb_stall_o, m0_wb_stall_o} !== ~exp_owner[r]) begin errors++; $display("FAIL rr_round%0d got stall %b%b exp %b", r, m1_wb_stall_o, m0_wb_stall_o, ~exp_owner[r]); end
         m0_wb_cyc_i = 0; m1_wb_cyc_i = 0;
         tick();
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      m0_wb_cyc_i = 1; m1_wb_cyc_i = 1;
      tick();  // GRANT0
      m0_wb_cyc_i = 0;
      tick();  // IDLE
      m0_wb_cyc_i = 1;
      #1;
      checks++; if (m0_wb_stall_o !== 1'b1 || m1_wb_stall_o !== 1'b1 || s_wb_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got stall %b%b cyc %b exp 11 0", m1_wb_stall_o, m0_wb_stall_o, s_wb_cyc_o); end
      tick();
      $display("txn back-to-back regrant stall m1m0=%b%b", m1_wb_stall_o, m0_wb_stall_o);
      checks++; if (m1_wb_stall_o !== 1'b0 || m0_wb_stall_o !== 1'b1) begin errors++; $display("FAIL b2b_waiter_wins got stall %b%b exp 01", m1_wb_stall_o, m0_wb_stall_o); end
      clear_inputs();
      tick();
   endtask

   task automatic test_outstanding_cap();
      int accepted;
      accepted = 0;
      do_reset();
      m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_adr_i = 32'h40;
      tick();  // GRANT1
      for (int c = 1; c <= 5; c++) begin
         s_wb_ack_i = (c == 4);
         #1;
         if (s_wb_stb_o && !s_wb_stall_i) accepted++;
         $display("txn cap cycle %0d stb=%b stall=%b ack=%b", c, s_wb_stb_o, m1_wb_stall_o, m1_wb_ack_o);
         if (c == 3) begin
            checks++; if (s_wb_stb_o !== 1'b0 || m1_wb_stall_o !== 1'b1) begin errors++; $display("FAIL cap_hold got stb %b stall %b exp 0 1", s_wb_stb_o, m1_wb_stall_o); end
         end
         if (c == 4) begin
            checks++; if (m1_wb_stall_o !== 1'b1 || m1_wb_ack_o !== 1'b1) begin errors++; $display("FAIL cap_ack got stall %b ack %b exp 1 1", m1_wb_stall_o, m1_wb_ack_o); end
            checks++; if (accepted !== 2) begin errors++; $display("FAIL cap_count got %0d exp 2", accepted); end
         end
         if (c == 5) begin
            checks++; if (s_wb_stb_o !== 1'b1 || m1_wb_stall_o !== 1'b0) begin errors++; $display("FAIL cap_third got stb %b stall %b exp 1 0", s_wb_stb_o, m1_wb_stall_o); end
         end
         tick();
      end
      s_wb_ack_i = 0;
      #1;
      checks++; if (dut.outstanding_reg !== 2'd2) begin errors++; $display("FAIL cap_final_out got %0d exp 2", dut.outstanding_reg); end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_abort_late_ack();
      do_reset();
      m0_wb_cyc_i = 1; m0_wb_stb_i = 1; m0_wb_adr_i = 32'h80; m1_wb_cyc_i = 1;
      tick();  // GRANT0, read accepted
      tick();
      m0_wb_cyc_i = 0; m0_wb_stb_i = 0;
      #1;
      checks++; if (dut.outstanding_reg !== 2'd1) begin errors++; $display("FAIL abort_out got %0d exp 1", dut.outstanding_reg); end
      tick();  // IDLE: late ack arrives
      s_wb_ack_i = 1;
      #1;
      checks++; if (m0_wb_ack_o !== 1'b0 || m1_wb_ack_o !== 1'b0) begin errors++; $display("FAIL late_ack_idle got %b%b exp 00", m1_wb_ack_o, m0_wb_ack_o); end
      tick();  // GRANT1: another late ack
      #1;
      $display("txn abort late ack under m1 grant");
      checks++; if (m0_wb_ack_o !== 1'b0 || m1_wb_ack_o !== 1'b0 || m1_wb_stall_o !== 1'b0) begin errors++; $display("FAIL late_ack_g1 got ack %b%b stall %b exp 00 0", m1_wb_ack_o, m0_wb_ack_o, m1_wb_stall_o); end
      tick();
      s_wb_ack_i = 0;
      #1;
      checks++; if (dut.outstanding_reg !== 2'd0) begin errors++; $display("FAIL late_ack_out got %0d exp 0", dut.outstanding_reg); end
      clear_inputs();
      tick();
   endtask

   task automatic test_byte_write();
      logic [31:0] wd;
      int          idx;
      do_reset();
      m1_wb_cyc_i = 1; m1_wb_stb_i = 1; m1_wb_we_i = 1;
      m1_wb_sel_i = 4'b0100; m1_wb_dat_i = 32'h00AB0000; m1_wb_adr_i = 32'h104;
      tick();  // GRANT1
      $display("txn m1 write adr=%h sel=%b dat=%h", s_wb_adr_o, s_wb_sel_o, s_wb_dat_o);
      checks++; if (s_wb_we_o !== 1'b1 || s_wb_stb_o !== 1'b1) begin errors++; $display("FAIL wr_we_stb got %b %b exp 1 1", s_wb_we_o, s_wb_stb_o); end
      checks++; if (s_wb_sel_o !== 4'b0100 || s_wb_dat_o !== 32'h00AB0000 || s_wb_adr_o !== 32'h104) begin errors++; $display("FAIL wr_pass got sel %b dat %h adr %h exp 0100 00ab0000 104", s_wb_sel_o, s_wb_dat_o, s_wb_adr_o); end
      // slave model stores the lanes it was given
      idx = int'(s_wb_adr_o[7:2]);
      wd  = mem[idx];
      for (int b = 0; b < 4; b++) if (s_wb_sel_o[b]) wd[8*b +: 8] = s_wb_dat_o[8*b +: 8];
      mem[idx] = wd;
      tick();
      m1_wb_stb_i = 0; m1_wb_we_i = 0; s_wb_ack_i = 1;
      #1;
      checks++; if (m1_wb_ack_o !== 1'b1) begin errors++; $display("FAIL wr_ack got %b exp 1", m1_wb_ack_o); end
      tick();
      s_wb_ack_i = 0; m1_wb_stb_i = 1; m1_wb_sel_i = 4'hF;
      tick();  // read accepted
      m1_wb_stb_i = 0; s_wb_ack_i = 1; s_wb_dat_i = mem[idx];
      #1;
      $display("txn m1 read adr=%h dat=%h", m1_wb_adr_i, m1_wb_dat_o);
      checks++; if (m1_wb_ack_o !== 1'b1 || m1_wb_dat_o !== 32'h00AB0000) begin errors++; $display("FAIL rd_back got ack %b dat %h exp 1 00ab0000", m1_wb_ack_o, m1_wb_dat_o); end
      tick();
      clear_inputs();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      clear_inputs();
      wb_rst_i = 1;
      test_reset();
      test_reset_mid_grant();
      test_single_read();
      test_round_robin();
      test_back_to_back();
      test_outstanding_cap();
      test_abort_late_ack();
      test_byte_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
